md_unit: RTL

Multiply/divide unit for the P7 pipeline, in the execute stage. It owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency, plus MTHI/MTLO writes. Its read port supplies the MD value that is carried down the pipe and selected by write-back when WDSel = `MD`. A `busy` flag lets the hazard unit stall any later HI/LO instruction in D.

---
 rtl/md_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit -- multiply/divide unit for the execute stage.
// Owns the HI/LO registers. MULT/MULTU/DIV/DIVU compute their result in the
// accepting cycle and park it in pend_hi/pend_lo. HI/LO are committed after a
// fixed busy window. MTHI/MTLO write HI/LO directly at the accepting edge.
//
// Parameters:
//   MUL_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES  busy cycles for DIV/DIVU   (1..15)
// Ports:
//   clk       clock, posedge
//   rst       async reset, active low
//   start     E-stage HI/LO op valid
//   op[2:0]   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   A, B      forwarded rs / rt operands
//   flush     suppresses start this cycle
//   hilo_sel  MDO select: 0 = LO, 1 = HI
//   MDO       combinational read of HI or LO
//   busy      mult/div in flight
//   HI, LO    architectural registers
module md_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        hilo_sel,
  output logic [31:0] MDO,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic [3:0]  r_cnt;
  logic        r_dz;

  logic [31:0] w_hi, w_lo, w_pend_hi, w_pend_lo;
  logic [3:0]  w_cnt;
  logic        w_dz;
  state_t      w_state;
  logic        w_acc;

  // Multiply: operands extended to 64 bits so the product is exact.
  logic [63:0] w_smul, w_umul;
  assign w_smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign w_umul = {32'd0, A} * {32'd0, B};

  // Divide on magnitudes, then fix signs. This makes 0x80000000 / -1 come
  // out as LO = 0x80000000, HI = 0 without a special case. The divisor is
  // forced to 1 on zero so the datapath never sees a divide by zero; the dz
  // flag discards that result anyway.
  logic        w_sdiv, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag, w_b_div, w_q, w_r, w_div_lo, w_div_hi;
  assign w_sdiv   = (op == 3'd2);
  assign w_a_neg  = w_sdiv & A[31];
  assign w_b_neg  = w_sdiv & B[31];
  assign w_a_mag  = w_a_neg ? (~A + 32'd1) : A;
  assign w_b_mag  = w_b_neg ? (~B + 32'd1) : B;
  assign w_b_div  = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_q      = w_a_mag / w_b_div;
  assign w_r      = w_a_mag % w_b_div;
  assign w_div_lo = (w_a_neg ^ w_b_neg) ? (~w_q + 32'd1) : w_q;
  assign w_div_hi = w_a_neg ? (~w_r + 32'd1) : w_r;

  assign busy    = (r_cnt != 4'd0);
  assign w_state = busy ? RUN : IDLE;
  assign w_acc   = start & ~flush & ~busy;

  always_comb begin
    w_hi      = r_hi;
    w_lo      = r_lo;
    w_pend_hi = r_pend_hi;
    w_pend_lo = r_pend_lo;
    w_cnt     = r_cnt;
    w_dz      = r_dz;
    case (w_state)
      RUN: begin
        // flush is deliberately ignored here: the op belongs to an older instr.
        w_cnt = r_cnt - 4'd1;
        if (r_cnt == 4'd1 && !r_dz) begin
          w_hi = r_pend_hi;
          w_lo = r_pend_lo;
        end
      end
      default: begin
        if (w_acc) begin
          case (op)
            3'd0: begin
              w_pend_hi = w_smul[63:32]; w_pend_lo = w_smul[31:0];
              w_cnt = MUL_N; w_dz = 1'b0;
            end
            3'd1: begin
              w_pend_hi = w_umul[63:32]; w_pend_lo = w_umul[31:0];
              w_cnt = MUL_N; w_dz = 1'b0;
            end
            3'd2, 3'd3: begin
              w_pend_hi = w_div_hi; w_pend_lo = w_div_lo;
              w_cnt = DIV_N; w_dz = (B == 32'd0);
            end
            3'd4:    w_hi = A;
            3'd5:    w_lo = A;
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_cnt     <= '0;
      r_dz      <= 1'b0;
    end else begin
      r_hi      <= w_hi;
      r_lo      <= w_lo;
      r_pend_hi <= w_pend_hi;
      r_pend_lo <= w_pend_lo;
      r_cnt     <= w_cnt;
      r_dz      <= w_dz;
    end
  end

  assign HI  = r_hi;
  assign LO  = r_lo;
  assign MDO = hilo_sel ? r_hi : r_lo;

endmodule
